// File: rtl/addroundkey_collect_if.sv
// Column-in / state-out bus for addroundkey_collect.
// state_par exists only when ARK_PARITY_EN is defined.
interface addroundkey_collect_if;
  logic [31:0]  col_in;
  logic         col_valid;
  logic         col_first;
  logic         col_ready;
  logic [127:0] round_key;
  logic [127:0] state_out;
  logic         state_valid;
  logic         state_ready;
  logic         seq_err;
`ifdef ARK_PARITY_EN
  logic [15:0]  state_par;
`endif

  // Both sides: a transfer happens on a rising edge where valid & ready are both 1;
  // valid holds its data until that edge, and ready never depends on valid.
  modport master (
    output col_in, col_valid, col_first, round_key, state_ready,
    input  col_ready, state_out, state_valid, seq_err
`ifdef ARK_PARITY_EN
    , input state_par
`endif
  );

  modport slave (
    input  col_in, col_valid, col_first, round_key, state_ready,
    output col_ready, state_out, state_valid, seq_err
`ifdef ARK_PARITY_EN
    , output state_par
`endif
  );
endinterface

// File: rtl/addroundkey_collect.sv
// Collects four MixColumns columns, XORs each with its round-key word, and presents the 128-bit state.
// Optional per-byte parity output (state_par) is enabled by defining ARK_PARITY_EN.
module addroundkey_collect #(
  parameter int NCOL      = 4,
  parameter bit KEY_LATCH = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  addroundkey_collect_if.slave bus,
  output logic                 o_dbg_state,
  output logic [1:0]           o_dbg_col_cnt
);

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_HOLD    = 1'b1
  } state_t;

  localparam logic [1:0] LAST_COL = 2'(NCOL - 1);

  state_t       r_state;
  logic [1:0]   r_col_cnt;
  logic [127:0] r_state_out;
  logic [127:0] r_key;
  logic         r_col_ready;
  logic         r_state_valid;
  logic         r_seq_err;

  logic         w_accept;
  logic         w_bad_first;
  logic         w_bad_cont;
  logic         w_write;
  logic         w_last;
  logic [1:0]   w_wr_idx;
  logic [6:0]   w_wr_lsb;
  logic [127:0] w_key_src;
  logic [31:0]  w_col_xor;
  logic [127:0] w_next_state;

  assign w_accept    = bus.col_valid & r_col_ready;
  assign w_bad_first = bus.col_first & (r_col_cnt != 2'd0);
  assign w_bad_cont  = ~bus.col_first & (r_col_cnt == 2'd0);
  assign w_write     = w_accept & ~w_bad_cont;
  assign w_last      = ~bus.col_first & (r_col_cnt == LAST_COL);

  // A col_first column always restarts at word 0, whatever the count says.
  assign w_wr_idx  = bus.col_first ? 2'd0 : r_col_cnt;
  assign w_wr_lsb  = {~w_wr_idx, 5'd0};
  assign w_key_src = (KEY_LATCH && (w_wr_idx != 2'd0)) ? r_key : bus.round_key;
  assign w_col_xor = bus.col_in ^ w_key_src[w_wr_lsb +: 32];

  always_comb begin
    w_next_state = r_state_out;
    w_next_state[w_wr_lsb +: 32] = w_col_xor;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_COLLECT;
      r_col_cnt     <= 2'd0;
      r_state_out   <= '0;
      r_key         <= '0;
      r_col_ready   <= 1'b1;
      r_state_valid <= 1'b0;
      r_seq_err     <= 1'b0;
    end else begin
      r_seq_err <= 1'b0;
      case (r_state)
        S_COLLECT: begin
          if (w_accept) begin
            r_seq_err <= w_bad_first | w_bad_cont;
            if (w_write) begin
              r_state_out <= w_next_state;
              if (bus.col_first) begin
                r_key     <= bus.round_key;
                r_col_cnt <= 2'd1;
              end else if (w_last) begin
                r_col_cnt     <= 2'd0;
                r_state       <= S_HOLD;
                r_state_valid <= 1'b1;
                r_col_ready   <= 1'b0;
              end else begin
                r_col_cnt <= r_col_cnt + 2'd1;
              end
            end
          end
        end
        S_HOLD: begin
          if (bus.state_ready) begin
            r_state       <= S_COLLECT;
            r_state_valid <= 1'b0;
            r_col_ready   <= 1'b1;
          end
        end
        default: r_state <= S_COLLECT;
      endcase
    end
  end

`ifdef ARK_PARITY_EN
  logic [15:0] r_state_par;
  logic [15:0] w_next_par;

  always_comb begin
    w_next_par = '0;
    for (int i = 0; i < 16; i++) begin
      w_next_par[i] = ^w_next_state[127 - 8*i -: 8];
    end
  end

  // Updated on every state_out write so it always matches state_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_par <= '0;
    end else if ((r_state == S_COLLECT) && w_write) begin
      r_state_par <= w_next_par;
    end
  end

  assign bus.state_par = r_state_par;
`endif

  assign bus.col_ready   = r_col_ready;
  assign bus.state_out   = r_state_out;
  assign bus.state_valid = r_state_valid;
  assign bus.seq_err     = r_seq_err;
  assign o_dbg_state     = r_state;
  assign o_dbg_col_cnt   = r_col_cnt;

endmodule

// File: tb/tb_addroundkey_collect.sv
// Bench for addroundkey_collect: queue-based round model, per-cycle compare, directed FIPS-197 vectors.
module tb_addroundkey_collect;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  addroundkey_collect_if bus ();
  logic       dbg_state;
  logic [1:0] dbg_col_cnt;

  addroundkey_collect dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus.slave),
    .o_dbg_state   (dbg_state),
    .o_dbg_col_cnt (dbg_col_cnt)
  );

  localparam logic [127:0] FIPS_KEY = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_OUT = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] ALT_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] ALT_OUT  = 128'h00102030405060708090a0b0c0d0e0f0;
  logic [31:0] fips_col [4] = '{32'h046681e5, 32'he0cb199a, 32'h48f8d37a, 32'h2806264c};
  logic [31:0] alt_col  [4] = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};

  int checks = 0;
  int errors = 0;
  int seq_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [127:0] exp_q[$];
  logic [31:0]  m_cols[$];
  logic [127:0] m_key;
  bit           m_holding = 0;
  bit           m_seq_exp = 0;
  bit           m_live = 0;

  function automatic logic [31:0] key_word(input logic [127:0] key, input int k);
    logic [127:0] t;
    t = key >> (32 * (3 - k));
    return t[31:0];
  endfunction

  function automatic logic [15:0] byte_par(input logic [127:0] v);
    logic [127:0] t;
    logic [15:0]  p;
    for (int i = 0; i < 16; i++) begin
      t = v >> (8 * (15 - i));
      p[i] = ^t[7:0];
    end
    return p;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_holding = 0;
      m_seq_exp = 0;
      m_cols.delete();
      exp_q.delete();
      m_live = 1;
    end else if (m_live) begin
      m_seq_exp = 0;
      if (m_holding) begin
        if (bus.state_ready) begin
          m_holding = 0;
          void'(exp_q.pop_front());
        end
      end else if (bus.col_valid) begin
        if (bus.col_first) begin
          if (m_cols.size() != 0) m_seq_exp = 1;
          m_cols.delete();
          m_key = bus.round_key;
          m_cols.push_back(bus.col_in ^ key_word(m_key, 0));
        end else if (m_cols.size() == 0) begin
          m_seq_exp = 1;
        end else begin
          m_cols.push_back(bus.col_in ^ key_word(dut.KEY_LATCH ? m_key : bus.round_key, m_cols.size()));
          if (m_cols.size() == 4) begin
            exp_q.push_back({m_cols[0], m_cols[1], m_cols[2], m_cols[3]});
            m_cols.delete();
            m_holding = 1;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_live && !rst) begin
      chk("col_ready", {127'd0, bus.col_ready}, {127'd0, !m_holding});
      chk("state_valid", {127'd0, bus.state_valid}, {127'd0, m_holding});
      chk("seq_err", {127'd0, bus.seq_err}, {127'd0, m_seq_exp});
      if (m_holding) begin
        if (exp_q.size() == 0) begin
          chk("exp_q_nonempty", 128'd0, 128'd1);
        end else begin
          chk("state_out", bus.state_out, exp_q[0]);
`ifdef ARK_PARITY_EN
          chk("state_par", {112'd0, bus.state_par}, {112'd0, byte_par(exp_q[0])});
`endif
        end
      end
      if (bus.seq_err) seq_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_col(input logic [31:0] c, input logic f);
    int n = 0;
    bus.col_in    = c;
    bus.col_first = f;
    bus.col_valid = 1'b1;
    while (!bus.col_ready && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.col_ready) begin
      checks++;
      errors++;
      $display("FAIL send_col_timeout: col_ready stayed %b, required 1", bus.col_ready);
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    bus.col_valid = 1'b0;
    bus.col_first = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    errors++;
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    bus.col_in      = '0;
    bus.col_valid   = 1'b0;
    bus.col_first   = 1'b0;
    bus.round_key   = FIPS_KEY;
    bus.state_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_state_out", bus.state_out, 128'd0);
    chk("rst_state_valid", {127'd0, bus.state_valid}, 128'd0);
    chk("rst_col_ready", {127'd0, bus.col_ready}, 128'd1);
    chk("rst_seq_err", {127'd0, bus.seq_err}, 128'd0);
    chk("rst_col_cnt", {126'd0, dbg_col_cnt}, 128'd0);

    // column without col_first right after reset is dropped
    send_col(32'hdeadbeef, 1'b0);
    idle(3);
    chk("drop_seq_cnt", seq_cnt, 1);
    chk("drop_col_cnt", {126'd0, dbg_col_cnt}, 128'd0);

    // FIPS-197 round 1, back to back
    for (int i = 0; i < 4; i++) send_col(fips_col[i], i == 0);
    chk("r1_valid", {127'd0, bus.state_valid}, 128'd1);
    chk("r1_out", bus.state_out, FIPS_OUT);
`ifdef ARK_PARITY_EN
    chk("r1_par0", {127'd0, bus.state_par[0]}, 128'd1);
    chk("r1_par1", {127'd0, bus.state_par[1]}, 128'd0);
    chk("r1_par15", {127'd0, bus.state_par[15]}, 128'd1);
`endif
    idle(2);

    // key latched on column 0, then backpressure with next column 0 waiting
    bus.state_ready = 1'b0;
    send_col(fips_col[0], 1'b1);
    bus.round_key = '1;
    for (int i = 1; i < 4; i++) send_col(fips_col[i], 1'b0);
    chk("kl_out", bus.state_out, FIPS_OUT);
    bus.round_key = FIPS_KEY;
    bus.col_in    = fips_col[0];
    bus.col_first = 1'b1;
    bus.col_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_ready", {127'd0, bus.col_ready}, 128'd0);
      chk("bp_out", bus.state_out, FIPS_OUT);
    end
    bus.state_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_col(fips_col[i], i == 0);
    chk("bp_next_out", bus.state_out, FIPS_OUT);
    idle(2);

    // col_first on the third column restarts the block
    send_col(32'h11111111, 1'b1);
    send_col(32'h22222222, 1'b0);
    for (int i = 0; i < 4; i++) send_col(fips_col[i], i == 0);
    chk("restart_out", bus.state_out, FIPS_OUT);
    idle(2);
    chk("restart_seq_cnt", seq_cnt, 2);

    // gapped columns, different key, delayed state_ready
    bus.round_key   = ALT_KEY;
    bus.state_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_col(alt_col[i], i == 0);
      if (i < 3) idle(2);
    end
    chk("alt_out", bus.state_out, ALT_OUT);
    idle(3);
    bus.state_ready = 1'b1;
    idle(2);

    // reset after two columns
    bus.round_key = FIPS_KEY;
    send_col(fips_col[0], 1'b1);
    send_col(fips_col[1], 1'b0);
    bus.col_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mrst_valid", {127'd0, bus.state_valid}, 128'd0);
    chk("mrst_out", bus.state_out, 128'd0);
    chk("mrst_cnt", {126'd0, dbg_col_cnt}, 128'd0);
    chk("mrst_ready", {127'd0, bus.col_ready}, 128'd1);
    for (int i = 0; i < 4; i++) send_col(fips_col[i], i == 0);
    chk("mrst_fresh_out", bus.state_out, FIPS_OUT);
    idle(3);

    chk("exp_q_drained", exp_q.size(), 0);
    chk("final_seq_cnt", seq_cnt, 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
